// File: rtl/l2_responder.sv
// l2_responder: direct-mapped, write-back L2 cache between an upstream cache
// and physical memory. Each line holds valid, dirty, tag and 128 bits of data.
//
// Address split: offset = address[3:0] (ignored), index = address[INDEX_BITS+3:4],
// tag = address[15:INDEX_BITS+4].
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   l2_address/l2_wdata     upstream request address and write line
//   l2_read/l2_write        upstream request strobes, held until l2_mem_resp
//   l2_dirty_out            upstream marks the written line dirty
//   l2_rdata/l2_dirty_in    returned line and its dirty bit (valid with l2_mem_resp)
//   l2_mem_resp             one-cycle completion pulse
//   pmem_*                  physical-memory read/write handshake
//   total_count/miss_count  saturating request and miss counters
module l2_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  l2_address,
    input  logic [127:0] l2_wdata,
    input  logic         l2_read,
    input  logic         l2_write,
    input  logic         l2_dirty_out,
    output logic [127:0] l2_rdata,
    output logic         l2_mem_resp,
    output logic         l2_dirty_in,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  total_count,
    output logic [15:0]  miss_count
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 12 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        RESP
    } state_t;

    state_t state;

    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [127:0]        data_arr [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  victim_dirty;

    // Request captured on leaving IDLE, used by WRITEBACK/FILL.
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_wr;

    logic addr_offset_unused;

    assign idx                = l2_address[INDEX_BITS+3:4];
    assign tag                = l2_address[15:INDEX_BITS+4];
    assign hit                = valid[idx] && (tag_arr[idx] == tag);
    assign victim_dirty       = valid[idx] && dirty[idx];
    assign addr_offset_unused = ^l2_address[3:0];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            total_count <= '0;
            miss_count  <= '0;
            l2_mem_resp <= 1'b0;
            l2_dirty_in <= 1'b0;
            l2_rdata    <= '0;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (l2_read || l2_write) begin
                        req_idx <= idx;
                        req_tag <= tag;
                        req_wr  <= l2_write;
                        if (!hit) begin
                            miss_count <= sat_inc(miss_count);
                        end
                        // Write wins when both strobes are high.
                        if (l2_write && (hit || !victim_dirty)) begin
                            data_arr[idx] <= l2_wdata;
                            tag_arr[idx]  <= tag;
                            valid[idx]    <= 1'b1;
                            dirty[idx]    <= l2_dirty_out | (hit & dirty[idx]);
                            l2_dirty_in   <= 1'b0;
                            l2_mem_resp   <= 1'b1;
                            state         <= RESP;
                        end else if (!l2_write && hit) begin
                            l2_rdata    <= data_arr[idx];
                            l2_dirty_in <= dirty[idx];
                            l2_mem_resp <= 1'b1;
                            state       <= RESP;
                        end else if (victim_dirty) begin
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_arr[idx], idx, 4'b0000};
                            pmem_wdata   <= data_arr[idx];
                            state        <= WRITEBACK;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {tag, idx, 4'b0000};
                            state        <= FILL;
                        end
                    end
                end

                WRITEBACK: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        if (req_wr) begin
                            // Upstream still holds the write line; install it now.
                            data_arr[req_idx] <= l2_wdata;
                            tag_arr[req_idx]  <= req_tag;
                            valid[req_idx]    <= 1'b1;
                            dirty[req_idx]    <= l2_dirty_out;
                            l2_dirty_in       <= 1'b0;
                            l2_mem_resp       <= 1'b1;
                            state             <= RESP;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, req_idx, 4'b0000};
                            state        <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (pmem_resp) begin
                        pmem_read         <= 1'b0;
                        data_arr[req_idx] <= pmem_rdata;
                        tag_arr[req_idx]  <= req_tag;
                        valid[req_idx]    <= 1'b1;
                        dirty[req_idx]    <= 1'b0;
                        l2_rdata          <= pmem_rdata;
                        l2_dirty_in       <= 1'b0;
                        l2_mem_resp       <= 1'b1;
                        state             <= RESP;
                    end
                end

                RESP: begin
                    l2_mem_resp <= 1'b0;
                    l2_dirty_in <= 1'b0;
                    total_count <= sat_inc(total_count);
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
